sram_read_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the read channels (AR/R) of the shared 64-bit AXI-style SRAM slave.
- Master 0 is the IFU instruction fetch; master 1 is the LSU load path.
- The LSU write channels (AW/W/B) connect directly to the slave and are outside this block.
- Only one read transaction is in flight at a time. The grant is held from grant until the R handshake completes.

---
 rtl/sram_read_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_read_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_arbiter.sv
// ---------------------------------------------------------------------------
// sram_read_arbiter
//
// Shares the read channels (AR/R) of the 64-bit SRAM slave between two
// masters:
//   master 0 : IFU instruction fetch
//   master 1 : LSU load path
// The LSU write channels bypass this block entirely.
//
// Only one read is in flight at a time. A grant is taken in IDLE, which
// costs one bubble cycle. The grant is held until the R handshake of that
// read completes.
//
// Configuration macro:
//   ARB_RR_EN  defined   : a tie in IDLE goes to the master that did not win
//                          last time (round-robin, LSU wins the first tie)
//              undefined : fixed priority, LSU over IFU
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ifu_ar_* / ifu_r_*        IFU read address / read data channels
//   lsu_ar_* / lsu_r_*        LSU read address / read data channels
//   s_ar_* / s_r_*            slave read address / read data channels
//
// States:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | nothing forwarded, arbitrate among pending ar_valid
//   GNT_IFU  | IFU owns the slave: AR phase until ar_done, then R phase
//   GNT_LSU  | LSU owns the slave: AR phase until ar_done, then R phase
//   (3 / X)  | unused encoding, behaves as IDLE
// ---------------------------------------------------------------------------
module sram_read_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_ar_valid,
    output logic              ifu_ar_ready,
    input  logic [ADDR_W-1:0] ifu_ar_addr,
    output logic              ifu_r_valid,
    input  logic              ifu_r_ready,
    output logic [1:0]        ifu_r_resp,
    output logic [DATA_W-1:0] ifu_r_data,

    input  logic              lsu_ar_valid,
    output logic              lsu_ar_ready,
    input  logic [ADDR_W-1:0] lsu_ar_addr,
    output logic              lsu_r_valid,
    input  logic              lsu_r_ready,
    output logic [1:0]        lsu_r_resp,
    output logic [DATA_W-1:0] lsu_r_data,

    output logic              s_ar_valid,
    input  logic              s_ar_ready,
    output logic [ADDR_W-1:0] s_ar_addr,
    input  logic              s_r_valid,
    output logic              s_r_ready,
    input  logic [1:0]        s_r_resp,
    input  logic [DATA_W-1:0] s_r_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IFU = 2'd1,
        GNT_LSU = 2'd2
    } state_t;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    state_t state, state_nxt;
    logic   ar_done, ar_done_nxt;
    logic   last_grant, last_grant_nxt;

    // Decoded grant and the selected master's request-side signals.
    logic              gnt_act;
    logic              gnt_lsu;
    logic              ar_phase;
    logic              sel_ar_valid;
    logic [ADDR_W-1:0] sel_ar_addr;
    logic              sel_r_ready;
    logic              ar_hs;
    logic              r_done;
    logic              pick_lsu;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ar_done    <= 1'b0;
            last_grant <= M_IFU;
        end else begin
            state      <= state_nxt;
            ar_done    <= ar_done_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Grant decode. Encoding 3 matches neither grant, so it forwards nothing.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_act      = (state == GNT_IFU) || (state == GNT_LSU);
        gnt_lsu      = (state == GNT_LSU);
        ar_phase     = gnt_act && !ar_done;
        sel_ar_valid = gnt_lsu ? lsu_ar_valid : ifu_ar_valid;
        sel_ar_addr  = gnt_lsu ? lsu_ar_addr  : ifu_ar_addr;
        sel_r_ready  = gnt_lsu ? lsu_r_ready  : ifu_r_ready;
    end

    // -----------------------------------------------------------------------
    // Arbitration between simultaneous requests in IDLE
    // -----------------------------------------------------------------------
`ifdef ARB_RR_EN
    always_comb begin
        pick_lsu = lsu_ar_valid && (!ifu_ar_valid || (last_grant == M_IFU));
    end
`else
    always_comb begin
        pick_lsu = lsu_ar_valid;
    end
`endif

    // -----------------------------------------------------------------------
    // Channel forwarding. After the address is accepted the AR path is shut
    // so a master that keeps ar_valid high cannot issue a second read. The R
    // path is a plain passthrough for the whole grant.
    // -----------------------------------------------------------------------
    always_comb begin
        s_ar_valid   = ar_phase && sel_ar_valid;
        s_ar_addr    = gnt_act ? sel_ar_addr : '0;
        s_r_ready    = gnt_act && sel_r_ready;

        ifu_ar_ready = ar_phase && !gnt_lsu && s_ar_ready;
        lsu_ar_ready = ar_phase &&  gnt_lsu && s_ar_ready;

        ifu_r_valid  = gnt_act && !gnt_lsu && s_r_valid;
        lsu_r_valid  = gnt_act &&  gnt_lsu && s_r_valid;

        ifu_r_data   = (gnt_act && !gnt_lsu) ? s_r_data : '0;
        ifu_r_resp   = (gnt_act && !gnt_lsu) ? s_r_resp : 2'b00;
        lsu_r_data   = gnt_lsu ? s_r_data : '0;
        lsu_r_resp   = gnt_lsu ? s_r_resp : 2'b00;

        ar_hs        = s_ar_valid && s_ar_ready;
        // Same condition as the granted master's r_valid & r_ready.
        r_done       = gnt_act && s_r_valid && sel_r_ready;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        ar_done_nxt    = ar_done;
        last_grant_nxt = last_grant;

        case (state)
            GNT_IFU, GNT_LSU: begin
                // Completion wins over a same-cycle address accept: the read
                // is finished either way and ar_done must start clear.
                if (r_done) begin
                    state_nxt      = IDLE;
                    ar_done_nxt    = 1'b0;
                    last_grant_nxt = gnt_lsu ? M_LSU : M_IFU;
                end else if (ar_hs) begin
                    ar_done_nxt = 1'b1;
                end
            end
            default: begin
                ar_done_nxt = 1'b0;
                if (lsu_ar_valid || ifu_ar_valid) begin
                    state_nxt = pick_lsu ? GNT_LSU : GNT_IFU;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sram_read_arbiter.sv
module tb_sram_read_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
    logic [ADDR_W-1:0] ifu_ar_addr;
    logic [1:0]        ifu_r_resp;
    logic [DATA_W-1:0] ifu_r_data;
    logic              lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
    logic [ADDR_W-1:0] lsu_ar_addr;
    logic [1:0]        lsu_r_resp;
    logic [DATA_W-1:0] lsu_r_data;
    logic              s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [ADDR_W-1:0] s_ar_addr;
    logic [1:0]        s_r_resp;
    logic [DATA_W-1:0] s_r_data;

    always #5 clk = ~clk;

    sram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
        .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_resp(ifu_r_resp),
        .ifu_r_data(ifu_r_data),
        .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
        .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready), .lsu_r_resp(lsu_r_resp),
        .lsu_r_data(lsu_r_data),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_resp(s_r_resp),
        .s_r_data(s_r_data)
    );

    logic [137:0] idle_out;
    logic [201:0] all_out;
    assign idle_out = {ifu_ar_ready, ifu_r_valid, ifu_r_resp, ifu_r_data,
                       lsu_ar_ready, lsu_r_valid, lsu_r_resp, lsu_r_data,
                       s_ar_valid, s_r_ready};
    assign all_out  = {idle_out, s_ar_addr};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // master models (index 0 = IFU, 1 = LSU)
    bit          m_pend[2], m_wait[2], m_hold[2];
    logic [63:0] m_addr[2];
    int          m_rpct[2], m_block[2], m_auto[2];
    // slave model
    bit          sl_busy;
    logic [63:0] sl_addr;
    int          sl_lat, sl_lat_max, sl_arpct;
    // transaction-level arbitration model
    bit          a_free, a_done;
    int          a_owner, a_last;
    // observation logs
    logic [63:0] sar_log[$];
    int          r_log[$], r_cyc_log[$], sarv_cyc_log[$];
    logic [63:0] rd0_log[$];
    int          rdy_cnt[2], rv_cnt[2];
    logic [63:0] last_data[2];
    logic [1:0]  last_resp[2];
    int          sarv_cnt, stall_cnt, rv0_first;
    bit          sarv_seen;
    logic [201:0] snap_all;
    logic [137:0] snap_idle;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
        return {~a[31:0], a[31:0] ^ 32'h1234_5678};
    endfunction

    function automatic logic [1:0] mem_resp(input logic [63:0] a);
        if (a == 64'h8000_0000) return 2'b00;
        return a[4:3];
    endfunction

    // Which master the arbiter should pick when it is free.
    function automatic int pick(input logic iv, input logic lv, input int last);
        if (iv && lv) begin
`ifdef ARB_RR_EN
            return (last == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return lv ? 1 : 0;
    endfunction

    task automatic reset_models();
        a_free = 1'b1; a_done = 1'b0; a_last = 0; a_owner = 0;
        sl_busy = 1'b0; sl_lat = 0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 0; m_wait[m] = 0; m_hold[m] = 0;
            m_block[m] = 0; m_auto[m] = 0;
        end
    endtask

    // One clock cycle: drive inputs from the models, sample and check away
    // from the edge, update the models, advance to the next negedge.
    task automatic cycle();
        logic        arv[2], arr[2], rv[2], rr[2];
        logic [1:0]  rsp[2];
        logic [63:0] rd[2], ara[2];
        logic [137:0] obs_g, exp_g;
        bit          s_ar_hs, s_r_hs;
        bit          ar_hs[2], r_hs[2];
        int          o, n;

        ifu_ar_valid = m_pend[0] | (m_hold[0] & m_wait[0]);
        lsu_ar_valid = m_pend[1] | (m_hold[1] & m_wait[1]);
        ifu_ar_addr  = m_addr[0];
        lsu_ar_addr  = m_addr[1];
        ifu_r_ready  = (m_block[0] > 0) ? 1'b0 : ($urandom_range(99) < m_rpct[0]);
        lsu_r_ready  = (m_block[1] > 0) ? 1'b0 : ($urandom_range(99) < m_rpct[1]);
        s_ar_ready   = !sl_busy && ($urandom_range(99) < sl_arpct);
        s_r_valid    = sl_busy && (sl_lat == 0);
        s_r_data     = s_r_valid ? mem_word(sl_addr) : {$urandom, $urandom};
        s_r_resp     = s_r_valid ? mem_resp(sl_addr) : 2'($urandom);
        #1;
        arv = '{ifu_ar_valid, lsu_ar_valid};
        arr = '{ifu_ar_ready, lsu_ar_ready};
        rv  = '{ifu_r_valid, lsu_r_valid};
        rr  = '{ifu_r_ready, lsu_r_ready};
        rsp = '{ifu_r_resp, lsu_r_resp};
        rd  = '{ifu_r_data, lsu_r_data};
        ara = '{ifu_ar_addr, lsu_ar_addr};
        snap_all  = all_out;
        snap_idle = idle_out;
        s_ar_hs = s_ar_valid && s_ar_ready;
        s_r_hs  = s_r_valid && s_r_ready;
        for (int m = 0; m < 2; m++) begin
            ar_hs[m] = arv[m] && arr[m];
            r_hs[m]  = rv[m] && rr[m];
        end

        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                if (arr[m]) rdy_cnt[m]++;
                if (rv[m])  rv_cnt[m]++;
            end
            if (s_ar_valid) sarv_cnt++;
            if (s_ar_valid && !sarv_seen) begin
                sarv_cyc_log.push_back(cyc);
                sarv_seen = 1;
            end
            if (s_r_valid && !s_r_ready) stall_cnt++;
            if (rv[0]) begin
                rd0_log.push_back(rd[0]);
                if (rv0_first < 0) rv0_first = cyc;
            end

            if (a_free) begin
                checks++;
                if (idle_out !== '0) begin
                    errors++;
                    $display("FAIL idle_fwd cyc=%0d got=%h required=0", cyc, idle_out);
                end
                if (arv[0] || arv[1]) begin
                    a_owner = pick(arv[0], arv[1], a_last);
                    a_free  = 0;
                    a_done  = 0;
                end
            end else begin
                o = a_owner;
                n = 1 - o;
                obs_g = {s_ar_valid, arr[o], arr[n], rv[o], rv[n], s_r_ready,
                         rsp[o], rsp[n], rd[o], rd[n]};
                exp_g = {(a_done ? 1'b0 : arv[o]), (a_done ? 1'b0 : s_ar_ready), 1'b0,
                         s_r_valid, 1'b0, rr[o], s_r_resp, 2'b00, s_r_data, 64'h0};
                checks++;
                if (obs_g !== exp_g) begin
                    errors++;
                    $display("FAIL grant_fwd cyc=%0d owner=%0d got=%h required=%h",
                             cyc, o, obs_g, exp_g);
                end
                if (!a_done) begin
                    checks++;
                    if (s_ar_addr !== ara[o]) begin
                        errors++;
                        $display("FAIL ar_addr cyc=%0d got=%h required=%h", cyc, s_ar_addr, ara[o]);
                    end
                end
                if (r_hs[o]) begin
                    a_free = 1;
                    a_last = o;
                end else if (s_ar_hs) begin
                    a_done = 1;
                end
            end

            for (int m = 0; m < 2; m++) begin
                if (ar_hs[m]) begin
                    m_pend[m] = 0;
                    m_wait[m] = 1;
                end
                if (r_hs[m]) begin
                    checks++;
                    if ({m_wait[m], rd[m], rsp[m]} !== {1'b1, mem_word(m_addr[m]), mem_resp(m_addr[m])}) begin
                        errors++;
                        $display("FAIL r_beat m=%0d cyc=%0d got=%b/%h/%0d required=1/%h/%0d",
                                 m, cyc, m_wait[m], rd[m], rsp[m],
                                 mem_word(m_addr[m]), mem_resp(m_addr[m]));
                    end
                    m_wait[m]    = 0;
                    last_data[m] = rd[m];
                    last_resp[m] = rsp[m];
                    r_log.push_back(m);
                    r_cyc_log.push_back(cyc);
                    sarv_seen = 0;
                    if (m_auto[m] > 0) begin
                        m_auto[m]--;
                        m_addr[m] = m_addr[m] + 64'd8;
                        m_pend[m] = 1;
                    end
                end
                if (rv[m] && !rr[m] && m_block[m] > 0) m_block[m]--;
            end

            if (s_ar_hs) begin
                sl_busy = 1;
                sl_addr = s_ar_addr;
                sl_lat  = $urandom_range(sl_lat_max, 0);
                sar_log.push_back(s_ar_addr);
            end else if (s_r_hs) begin
                sl_busy = 0;
            end else if (sl_busy && sl_lat > 0) begin
                sl_lat--;
            end
        end

        @(posedge clk);
        cyc++;
        if (rst) reset_models();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_models();
        for (int m = 0; m < 2; m++) begin
            m_rpct[m] = 100; m_addr[m] = '0;
            rdy_cnt[m] = 0; rv_cnt[m] = 0;
        end
        sl_arpct = 100; sl_lat_max = 0;
        sar_log.delete(); r_log.delete(); r_cyc_log.delete();
        sarv_cyc_log.delete(); rd0_log.delete();
        sarv_cnt = 0; stall_cnt = 0; rv0_first = -1; sarv_seen = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_ar_valid = 1; lsu_ar_valid = 1; ifu_r_ready = 1; lsu_r_ready = 1;
        ifu_ar_addr = 64'h8000_0000; lsu_ar_addr = 64'h8000_1000;
        s_ar_ready = 1; s_r_valid = 1; s_r_resp = 2'b11; s_r_data = 64'hdead_beef_cafe_f00d;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_outputs step=%0d got=%h required=0", i, all_out);
            end
        end
    endtask

    task automatic test_single_ifu();
        do_reset();
        sl_arpct = 50; sl_lat_max = 2;
        m_addr[0] = 64'h8000_0000; m_pend[0] = 1;
        for (int i = 0; i < 60 && r_log.size() == 0; i++) cycle();
        checks++;
        if (r_log.size() != 1) begin
            errors++;
            $display("FAIL single_done got=%0d required=1", r_log.size());
        end
        checks++;
        if (rdy_cnt[0] != 1) begin
            errors++;
            $display("FAIL single_ar_ready_pulses got=%0d required=1", rdy_cnt[0]);
        end
        checks++;
        if ({last_data[0], last_resp[0]} !== {64'h0000_0013_0000_0093, 2'b00}) begin
            errors++;
            $display("FAIL single_data got=%h/%0d required=0000001300000093/0", last_data[0], last_resp[0]);
        end
        checks++;
        if (rv_cnt[1] != 0) begin
            errors++;
            $display("FAIL single_lsu_rvalid got=%0d required=0", rv_cnt[1]);
        end
        cycle();
        checks++;
        if (snap_idle !== '0) begin
            errors++;
            $display("FAIL single_back_idle got=%h required=0", snap_idle);
        end
    endtask

    task automatic test_tie();
        do_reset();
        sl_arpct = 70; sl_lat_max = 3; m_rpct[0] = 60; m_rpct[1] = 60;
        m_addr[0] = 64'h8000_0000; m_addr[1] = 64'h8000_1000;
        m_pend[0] = 1; m_pend[1] = 1;
        for (int i = 0; i < 200 && r_log.size() < 2; i++) cycle();
        checks++;
        if (sar_log.size() != 2) begin
            errors++;
            $display("FAIL tie_ar_count got=%0d required=2", sar_log.size());
        end else begin
            checks++;
            if ({sar_log[0], sar_log[1]} !== {64'h8000_1000, 64'h8000_0000}) begin
                errors++;
                $display("FAIL tie_ar_order got=%h,%h required=80001000,80000000", sar_log[0], sar_log[1]);
            end
        end
        checks++;
        if (r_log.size() != 2 || r_log[0] != 1 || r_log[1] != 0) begin
            errors++;
            $display("FAIL tie_r_order got_count=%0d required=LSU then IFU", r_log.size());
        end
    endtask

    task automatic test_lsu_during_r();
        int  lsu_rdy_before;
        bit  got;
        lsu_rdy_before = -1;
        got = 0;
        do_reset();
        m_block[0] = 3;
        m_addr[0] = 64'h8000_0000; m_pend[0] = 1;
        for (int i = 0; i < 50 && !m_wait[0]; i++) cycle();
        m_addr[1] = 64'h8000_1000; m_pend[1] = 1;
        for (int i = 0; i < 100 && r_log.size() < 2; i++) begin
            cycle();
            if (r_log.size() >= 1 && !got) begin
                lsu_rdy_before = rdy_cnt[1];
                got = 1;
            end
        end
        checks++;
        if (lsu_rdy_before != 0) begin
            errors++;
            $display("FAIL lsu_ready_while_ifu got=%0d required=0", lsu_rdy_before);
        end
        checks++;
        if (r_log.size() != 2 || sarv_cyc_log.size() != 2) begin
            errors++;
            $display("FAIL lsu_after_ifu_done got=%0d/%0d required=2/2", r_log.size(), sarv_cyc_log.size());
        end else begin
            checks++;
            if (sarv_cyc_log[1] - r_cyc_log[0] != 2) begin
                errors++;
                $display("FAIL lsu_grant_gap got=%0d required=2", sarv_cyc_log[1] - r_cyc_log[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_d;
        int          bad;
        exp_d = mem_word(64'h8000_2000);
        bad = 0;
        do_reset();
        m_hold[0] = 1; m_block[0] = 4;
        m_addr[0] = 64'h8000_2000; m_pend[0] = 1;
        for (int i = 0; i < 50 && r_log.size() == 0; i++) cycle();
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (stall_cnt != 4) begin
            errors++;
            $display("FAIL bp_stall_cycles got=%0d required=4", stall_cnt);
        end
        foreach (rd0_log[i]) if (rd0_log[i] !== exp_d) bad++;
        checks++;
        if (bad != 0 || rd0_log.size() != 5) begin
            errors++;
            $display("FAIL bp_data_stable bad=%0d beats=%0d required=0/5", bad, rd0_log.size());
        end
        checks++;
        if (r_log.size() != 1 || r_cyc_log[0] - rv0_first != 4) begin
            errors++;
            $display("FAIL bp_completion count=%0d required=1 at rvalid+4", r_log.size());
        end
        checks++;
        if (sarv_cnt != 1 || sar_log.size() != 1) begin
            errors++;
            $display("FAIL bp_single_ar got=%0d/%0d required=1/1", sarv_cnt, sar_log.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_block[1] = 20;
        m_addr[1] = 64'h8000_4000; m_pend[1] = 1;
        for (int i = 0; i < 50 && !m_wait[1]; i++) cycle();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        checks++;
        if (snap_all !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h required=0", snap_all);
        end
        m_addr[0] = 64'h8000_3000; m_pend[0] = 1;
        for (int i = 0; i < 50 && r_log.size() == 0; i++) cycle();
        checks++;
        if (r_log.size() != 1 || r_log[0] != 0 || last_data[0] !== mem_word(64'h8000_3000)) begin
            errors++;
            $display("FAIL midrst_fresh_ifu count=%0d data=%h required=1/%h",
                     r_log.size(), last_data[0], mem_word(64'h8000_3000));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, req;
`ifdef ARB_RR_EN
        req = 4'b1010;
`else
        req = 4'b1100;
`endif
        got = '0;
        do_reset();
        sl_lat_max = 1;
        m_addr[0] = 64'h1000_0000; m_addr[1] = 64'h2000_0000;
        m_auto[0] = 1; m_auto[1] = 1;
        m_pend[0] = 1; m_pend[1] = 1;
        for (int i = 0; i < 200 && r_log.size() < 4; i++) cycle();
        foreach (r_log[i]) if (i < 4) got[3-i] = r_log[i][0];
        checks++;
        if (r_log.size() != 4 || got !== req) begin
            errors++;
            $display("FAIL b2b_grant_order count=%0d got=%b required=%b (1=LSU)", r_log.size(), got, req);
        end
    endtask

    task automatic test_random();
        int issued[2];
        int n_ifu;
        issued = '{0, 0};
        n_ifu = 0;
        do_reset();
        sl_arpct = 60; sl_lat_max = 3; m_rpct[0] = 70; m_rpct[1] = 70;
        for (int i = 0; i < 4000 && r_log.size() < 50; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!m_pend[m] && !m_wait[m] && issued[m] < 25 && $urandom_range(99) < 30) begin
                    m_addr[m] = {m[0] ? 32'h4 : 32'h0, $urandom} & ~64'h7;
                    m_hold[m] = $urandom_range(1);
                    m_pend[m] = 1;
                    issued[m]++;
                end
            end
            cycle();
        end
        foreach (r_log[i]) if (r_log[i] == 0) n_ifu++;
        checks++;
        if (r_log.size() != 50 || n_ifu != 25) begin
            errors++;
            $display("FAIL random_completions got=%0d ifu=%0d required=50/25", r_log.size(), n_ifu);
        end
    endtask

    initial begin
        reset_models();
        test_reset();
        test_single_ifu();
        test_tie();
        test_lsu_during_r();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
